// File: rtl/cart_load_arbiter_if.sv
// Upload stream, Z80 cartridge window and cartridge RAM port bundle.
// The design drives the slave side; the HPS/CPU/RAM environment is master.
interface cart_load_arbiter_if #(
  parameter int CART_AW = 14
);
  logic               download;
  logic               upload;
  logic [7:0]         upload_index;
  logic [24:0]        upload_addr;
  logic [7:0]         upload_data;
  logic [15:0]        cpu_addr;
  logic               cpu_rd;
  logic [7:0]         cpu_din;
  logic               cpu_ack;
  logic               cpu_wait;
  logic               cpu_reset_hold;
  logic [CART_AW-1:0] ram_addr;
  logic               ram_we;
  logic [7:0]         ram_wdata;
  logic [7:0]         ram_rdata;
  logic               cart_valid;
  logic [CART_AW:0]   cart_size;
  logic               overflow;

  modport slave (
    input  download, upload, upload_index,
    input  upload_addr, upload_data,
    input  cpu_addr, cpu_rd, ram_rdata,
    output cpu_din, cpu_ack, cpu_wait,
    output cpu_reset_hold,
    output ram_addr, ram_we, ram_wdata,
    output cart_valid, cart_size, overflow
  );

  modport master (
    output download, upload, upload_index,
    output upload_addr, upload_data,
    output cpu_addr, cpu_rd, ram_rdata,
    input  cpu_din, cpu_ack, cpu_wait,
    input  cpu_reset_hold,
    input  ram_addr, ram_we, ram_wdata,
    input  cart_valid, cart_size, overflow
  );
endinterface

// File: rtl/cart_load_arbiter.sv
// Cartridge image loader: buffers HPS upload bytes into cart RAM and
// shares the single RAM port with Z80 reads of 0x2000-0x5FFF.
module cart_load_arbiter #(
  parameter int         CART_AW     = 14,
  parameter logic [7:0] CART_INDEX  = 8'd1,
  parameter int         HOLD_CYCLES = 16
) (
  input logic clk,
  input logic reset,
  cart_load_arbiter_if.slave bus
);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] HOLD = 3'd2;
  localparam logic [2:0] RD1  = 3'd3;
  localparam logic [2:0] RD2  = 3'd4;

  logic [2:0]         state;
  logic [CW-1:0]      cnt;
  logic               dl_q;
  logic [7:0]         din_q;
  logic               valid_q;
  logic [CART_AW:0]   size_q;
  logic               ovf_q;

  logic [CART_AW-1:0] f_addr [2];
  logic [7:0]         f_data [2];
  logic               wp;
  logic               rp;
  logic [1:0]         fill;

  logic               match;
  logic               in_range;
  logic               acc;
  logic               empty;
  logic               full;
  logic               pop;
  logic               push;
  logic               drop;
  logic               start;
  logic               hit;
  logic               grant;
  logic [CART_AW-1:0] rd_addr;
  logic [CART_AW:0]   wr_end;
  logic [CART_AW:0]   base_size;
  logic [CART_AW:0]   next_size;

  assign match    = bus.upload_index == CART_INDEX;
  assign in_range = bus.upload_addr[24:CART_AW] == '0;
  assign acc      = bus.upload & match & in_range;
  assign empty    = fill == 2'd0;
  assign full     = fill == 2'd2;
  assign pop      = !empty;
  assign push     = acc & (!full | pop);
  assign drop     = bus.upload & match
                  & (!in_range | (full & !pop));
  assign start    = bus.download & !dl_q & match;

  assign hit     = bus.cpu_addr >= 16'h2000
                && bus.cpu_addr < 16'h6000;
  assign rd_addr = CART_AW'(bus.cpu_addr - 16'h2000);

  // a read may only start once the write path is quiet
  assign grant = state == IDLE && !start && hit
              && bus.cpu_rd && empty
              && !(bus.download && match);

  assign wr_end = (CART_AW+1)'(bus.upload_addr[CART_AW-1:0])
                + (CART_AW+1)'(1);
  assign base_size = start ? '0 : size_q;
  assign next_size = (wr_end > base_size) ? wr_end : base_size;

  assign bus.ram_we    = !empty;
  assign bus.ram_wdata = empty ? 8'h00 : f_data[rp];
  assign bus.ram_addr  = !empty ? f_addr[rp]
                       : (grant || state == RD1) ? rd_addr
                       : '0;

  assign bus.cpu_din        = din_q;
  assign bus.cpu_ack        = state == RD2;
  assign bus.cpu_reset_hold = state == LOAD || state == HOLD;
  assign bus.cpu_wait       = !reset
    && (state == LOAD || state == HOLD
     || ((state == IDLE || state == RD1)
         && hit && bus.cpu_rd));

  assign bus.cart_valid = valid_q;
  assign bus.cart_size  = size_q;
  assign bus.overflow   = ovf_q;

  always_ff @(posedge clk) begin
    if (push) begin
      f_addr[wp] <= bus.upload_addr[CART_AW-1:0];
      f_data[wp] <= bus.upload_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp   <= 1'b0;
      rp   <= 1'b0;
      fill <= 2'd0;
    end else begin
      if (push) wp <= ~wp;
      if (pop)  rp <= ~rp;
      fill <= fill + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      dl_q    <= 1'b0;
      din_q   <= 8'h00;
      valid_q <= 1'b0;
      size_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      dl_q <= bus.download;
      if (state == RD1) din_q <= bus.ram_rdata;
      if (start) ovf_q <= drop;
      else if (drop) ovf_q <= 1'b1;
      if (push) size_q <= next_size;
      else if (start) size_q <= '0;
      if (start) valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) state <= LOAD;
          else if (grant) state <= RD1;
        end
        LOAD: begin
          if (!bus.download && empty) begin
            state <= HOLD;
            cnt   <= CW'(HOLD_CYCLES - 1);
          end
        end
        HOLD: begin
          if (start) begin
            state <= LOAD;
          end else if (cnt == '0) begin
            state   <= IDLE;
            valid_q <= size_q != '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RD1: state <= RD2;
        RD2: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
